// File: rtl/sa_r8_pkg.sv
// Shared definitions for the radix-8 edge feeder: group count, FSM states
// and the {n,q,t,d,s} flag encoding used by the recoder.
package sa_r8_pkg;

    function automatic int r8_group_count(input int width);
        return (width >> 2) + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feed_state_e;

    // Flag vector layout is {n, q, t, d, s}
    localparam logic [4:0] FLAG_ZERO = 5'b00000;
    localparam logic [4:0] FLAG_S    = 5'b00001;
    localparam logic [4:0] FLAG_D    = 5'b00010;
    localparam logic [4:0] FLAG_T    = 5'b00100;
    localparam logic [4:0] FLAG_Q    = 5'b01000;
    localparam logic [4:0] FLAG_N    = 5'b10000;

endpackage

// File: rtl/booth_r8_enc.sv
// Radix-8 Booth recoder for one 4-bit overlapping group {x[3i+2..3i], x[3i-1]}:
// one-hot magnitude (1/2/3/4) plus a sign flag that is set only for negative digits.
module booth_r8_enc
    import sa_r8_pkg::*;
(
    input  logic [3:0] grp,
    output logic       s,
    output logic       d,
    output logic       t,
    output logic       q,
    output logic       n
);

    logic [4:0] flags;

    always_comb begin
        flags = FLAG_ZERO;
        case (grp)
            4'b0000, 4'b1111: flags = FLAG_ZERO;
            4'b0001, 4'b0010: flags = FLAG_S;
            4'b0011, 4'b0100: flags = FLAG_D;
            4'b0101, 4'b0110: flags = FLAG_T;
            4'b0111:          flags = FLAG_Q;
            4'b1000:          flags = FLAG_Q | FLAG_N;
            4'b1001, 4'b1010: flags = FLAG_T | FLAG_N;
            4'b1011, 4'b1100: flags = FLAG_D | FLAG_N;
            4'b1101, 4'b1110: flags = FLAG_S | FLAG_N;
            default:          flags = FLAG_ZERO;
        endcase
    end

    assign {n, q, t, d, s} = flags;

endmodule

// File: rtl/sa_r8_edge_feeder.sv
// Edge feeder for the radix-8 output-stationary array: accepts K beats, recodes X,
// precomputes 3*Y through two register stages, then drains with zero beats and pulses DONE.
module sa_r8_edge_feeder
    import sa_r8_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int ARRAY_DIM = 8,
    parameter  int KW        = 8,
    localparam int GC        = r8_group_count(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [KW-1:0]      K_LEN,
    input  logic [WIDTH-1:0]   X_IN,
    input  logic [WIDTH-1:0]   Y_IN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [GC-1:0]      S_OUT,
    output logic [GC-1:0]      D_OUT,
    output logic [GC-1:0]      T_OUT,
    output logic [GC-1:0]      Q_OUT,
    output logic [GC-1:0]      N_OUT,
    output logic [WIDTH-1:0]   Y_OUT,
    output logic [WIDTH+1:0]   TMY_OUT,
    output logic               OUT_VALID,
    output logic               OUT_LAST,
    output logic               BUSY,
    output logic               DONE
);

    localparam int FLUSH_CYCLES = 2 * ARRAY_DIM - 2;
    localparam int FW           = $clog2(2 * ARRAY_DIM - 1);

    feed_state_e     state_reg, state_next;
    logic [KW-1:0]   cnt_reg, cnt_next;
    logic [FW-1:0]   fcnt_reg, fcnt_next;
    logic            done_reg, done_next;
    logic            accept;
    logic            accept_last;

    assign accept      = IN_VALID && (state_reg == STREAM);
    assign accept_last = accept && (cnt_reg == KW'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            fcnt_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fcnt_reg  <= fcnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fcnt_next  = fcnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    if (K_LEN != '0) begin
                        state_next = STREAM;
                        cnt_next   = K_LEN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    cnt_next = cnt_reg - KW'(1);
                    if (accept_last) begin
                        state_next = FLUSH;
                        fcnt_next  = FW'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                fcnt_next = fcnt_reg - FW'(1);
                if (fcnt_reg == FW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: a cycle with no accepted beat loads zeros, which recode to all-zero flags.
    logic signed [WIDTH-1:0] s1_x_reg;
    logic signed [WIDTH-1:0] s1_y_reg;
    logic                    s1_valid_reg;
    logic                    s1_last_reg;

    always_ff @(posedge CLK) begin
        if (RST || !accept) begin
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_x_reg     <= X_IN;
            s1_y_reg     <= Y_IN;
            s1_valid_reg <= 1'b1;
            s1_last_reg  <= accept_last;
        end
    end

    logic signed [3*GC-1:0] x_ext;
    logic [3*GC:0]          x_grp;
    logic [GC-1:0]          enc_s, enc_d, enc_t, enc_q, enc_n;
    logic signed [WIDTH+1:0] y_ext;
    logic signed [WIDTH+1:0] tmy;

    assign x_ext = (3*GC)'(s1_x_reg);
    assign x_grp = {x_ext, 1'b0};

    generate
        for (genvar gi = 0; gi < GC; gi++) begin : g_enc
            booth_r8_enc u_enc (
                .grp (x_grp[3*gi+3 -: 4]),
                .s   (enc_s[gi]),
                .d   (enc_d[gi]),
                .t   (enc_t[gi]),
                .q   (enc_q[gi]),
                .n   (enc_n[gi])
            );
        end
    endgenerate

    // Two guard bits make 3*Y exact for every WIDTH-bit signed Y.
    assign y_ext = (WIDTH+2)'(s1_y_reg);
    assign tmy   = y_ext + (y_ext <<< 1);

    logic [GC-1:0]    s2_s_reg, s2_d_reg, s2_t_reg, s2_q_reg, s2_n_reg;
    logic [WIDTH-1:0] s2_y_reg;
    logic [WIDTH+1:0] s2_tmy_reg;
    logic             s2_valid_reg;
    logic             s2_last_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_s_reg     <= '0;
            s2_d_reg     <= '0;
            s2_t_reg     <= '0;
            s2_q_reg     <= '0;
            s2_n_reg     <= '0;
            s2_y_reg     <= '0;
            s2_tmy_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            s2_s_reg     <= enc_s;
            s2_d_reg     <= enc_d;
            s2_t_reg     <= enc_t;
            s2_q_reg     <= enc_q;
            s2_n_reg     <= enc_n;
            s2_y_reg     <= s1_y_reg;
            s2_tmy_reg   <= tmy;
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    assign S_OUT     = s2_s_reg;
    assign D_OUT     = s2_d_reg;
    assign T_OUT     = s2_t_reg;
    assign Q_OUT     = s2_q_reg;
    assign N_OUT     = s2_n_reg;
    assign Y_OUT     = s2_y_reg;
    assign TMY_OUT   = s2_tmy_reg;
    assign OUT_VALID = s2_valid_reg;
    assign OUT_LAST  = s2_last_reg;
    assign IN_READY  = (state_reg == STREAM);
    assign BUSY      = (state_reg != IDLE);
    assign DONE      = done_reg;

endmodule

// File: tb/tb_sa_r8_edge_feeder.sv
// Directed scoreboard bench for sa_r8_edge_feeder: expected beats are queued at
// acceptance and checked against every output cycle, together with DONE timing.
module tb_sa_r8_edge_feeder;

    localparam int WIDTH     = 16;
    localparam int ARRAY_DIM = 8;
    localparam int KW        = 8;
    localparam int GC        = (WIDTH >> 2) + 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic [KW-1:0]     K_LEN;
    logic [WIDTH-1:0]  X_IN;
    logic [WIDTH-1:0]  Y_IN;
    logic              IN_VALID;
    logic              IN_READY;
    logic [GC-1:0]     S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT;
    logic [WIDTH-1:0]  Y_OUT;
    logic [WIDTH+1:0]  TMY_OUT;
    logic              OUT_VALID;
    logic              OUT_LAST;
    logic              BUSY;
    logic              DONE;

    sa_r8_edge_feeder #(
        .WIDTH     (WIDTH),
        .ARRAY_DIM (ARRAY_DIM),
        .KW        (KW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .K_LEN     (K_LEN),
        .X_IN      (X_IN),
        .Y_IN      (Y_IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .S_OUT     (S_OUT),
        .D_OUT     (D_OUT),
        .T_OUT     (T_OUT),
        .Q_OUT     (Q_OUT),
        .N_OUT     (N_OUT),
        .Y_OUT     (Y_OUT),
        .TMY_OUT   (TMY_OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int               cyc;
        logic [GC-1:0]    s, d, t, q, n;
        logic [WIDTH-1:0] y;
        logic [WIDTH+1:0] tmy;
        logic             last;
    } exp_t;

    exp_t sb[$];
    bit   done_at[int];
    int   cyc        = 0;
    int   tests_run  = 0;
    int   fails      = 0;
    bit   mon_en     = 1'b0;
    int   m_cnt      = 0;
    bit   m_stream   = 1'b0;
    int   last_done  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference recoding straight from digit = -4*b3 + 2*b2 + b1 + b0 on the integer value.
    function automatic exp_t model(input int c, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic last);
        exp_t e;
        int   xi;
        int   dg;
        int   mag;
        xi = int'($signed(x));
        e.cyc = c;
        e.s = '0; e.d = '0; e.t = '0; e.q = '0; e.n = '0;
        for (int i = 0; i < GC; i++) begin
            dg = -4 * ((xi >>> (3*i+2)) & 1) + 2 * ((xi >>> (3*i+1)) & 1)
                 + ((xi >>> (3*i)) & 1) + ((i == 0) ? 0 : ((xi >>> (3*i-1)) & 1));
            mag = (dg < 0) ? -dg : dg;
            if (mag == 1) e.s[i] = 1'b1;
            if (mag == 2) e.d[i] = 1'b1;
            if (mag == 3) e.t[i] = 1'b1;
            if (mag == 4) e.q[i] = 1'b1;
            e.n[i] = (dg < 0);
        end
        e.y    = y;
        e.tmy  = (WIDTH+2)'(int'($signed(y)) * 3);
        e.last = last;
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        bit   has;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("sb_stale_beat", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
            has = 1'b0;
            e.cyc = cyc;
            e.s = '0; e.d = '0; e.t = '0; e.q = '0; e.n = '0;
            e.y = '0; e.tmy = '0; e.last = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e   = sb.pop_front();
                has = 1'b1;
            end
            chk("out_valid", 64'(OUT_VALID), 64'(has));
            chk("out_last",  64'(OUT_LAST),  64'(e.last));
            chk("s_out",     64'(S_OUT),     64'(e.s));
            chk("d_out",     64'(D_OUT),     64'(e.d));
            chk("t_out",     64'(T_OUT),     64'(e.t));
            chk("q_out",     64'(Q_OUT),     64'(e.q));
            chk("n_out",     64'(N_OUT),     64'(e.n));
            chk("y_out",     64'(Y_OUT),     64'(e.y));
            chk("tmy_out",   64'(TMY_OUT),   64'(e.tmy));
            chk("done",      64'(DONE),      64'(done_at.exists(cyc)));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_beat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic v);
        X_IN     = x;
        Y_IN     = y;
        IN_VALID = v;
        chk("in_ready", 64'(IN_READY), 64'(m_stream));
        if (v && m_stream) begin
            sb.push_back(model(cyc + 2, x, y, m_cnt == 1));
            m_cnt--;
            if (m_cnt == 0) begin
                m_stream  = 1'b0;
                last_done = cyc + 2*ARRAY_DIM - 1;
                done_at[last_done] = 1'b1;
            end
        end
        tick();
    endtask

    task automatic start_job(input int k);
        START = 1'b1;
        K_LEN = KW'(k);
        if (k == 0) begin
            last_done = cyc + 1;
            done_at[last_done] = 1'b1;
        end
        tick();
        START = 1'b0;
        if (k != 0) begin
            m_stream = 1'b1;
            m_cnt    = k;
        end
        chk("busy_after_start",  64'(BUSY),     64'(k != 0));
        chk("ready_after_start", 64'(IN_READY), 64'(k != 0));
    endtask

    // Runs through the drain; with probe set, START is held during FLUSH and must be ignored.
    task automatic wait_done(input bit probe);
        for (int i = 0; i < 4*ARRAY_DIM && cyc < last_done; i++) begin
            START = probe && (cyc < last_done - 1);
            K_LEN = KW'(3);
            chk("ready_in_flush", 64'(IN_READY), 64'(0));
            chk("busy_in_flush",  64'(BUSY),     64'(1));
            tick();
        end
        START = 1'b0;
        chk("busy_at_done",  64'(BUSY),     64'(0));
        chk("ready_at_done", 64'(IN_READY), 64'(0));
    endtask

    initial begin
        RST      = 1'b1;
        START    = 1'b0;
        K_LEN    = '0;
        X_IN     = '0;
        Y_IN     = '0;
        IN_VALID = 1'b0;
        repeat (3) tick();
        RST    = 1'b0;
        mon_en = 1'b1;
        chk("reset_ready", 64'(IN_READY), 64'(0));
        chk("reset_busy",  64'(BUSY),     64'(0));

        // Single-beat job: X=3 -> T[0], TMY=15
        start_job(1);
        drive_beat(16'd3, 16'd5, 1'b1);
        wait_done(1'b1);

        // Four beats with bubbles; starts in the same cycle as the previous DONE
        start_job(4);
        drive_beat(16'd4,    16'h8000, 1'b1);
        drive_beat(16'h1234, 16'h7777, 1'b0);
        drive_beat(16'hFFFF, 16'h7FFF, 1'b1);
        drive_beat(16'h8000, 16'h0007, 1'b1);
        drive_beat(16'hAAAA, 16'h5555, 1'b0);
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        wait_done(1'b0);

        // Zero-length job: DONE next cycle, never busy
        start_job(0);

        // Abort by reset after 2 of 5 beats; a START mid-stream must be ignored
        start_job(5);
        START = 1'b1;
        K_LEN = KW'(1);
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        START = 1'b0;
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        RST      = 1'b1;
        IN_VALID = 1'b1;
        START    = 1'b1;
        K_LEN    = KW'(3);
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        m_stream = 1'b0;
        m_cnt    = 0;
        tick();
        RST      = 1'b0;
        START    = 1'b0;
        IN_VALID = 1'b0;
        chk("ready_after_rst", 64'(IN_READY), 64'(0));
        chk("busy_after_rst",  64'(BUSY),     64'(0));
        repeat (2*ARRAY_DIM + 4) tick();

        // Clean job after the abort
        start_job(3);
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        drive_beat(16'($urandom), 16'($urandom), 1'b0);
        drive_beat(16'($urandom), 16'($urandom), 1'b1);
        wait_done(1'b1);
        start_job(0);
        repeat (4) tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sa_r8_edge_feeder.md
Name: sa_r8_edge_feeder

Overview:
- Edge feeder that sits directly upstream of the radix-8 output-stationary PE column/row in the systolic array.
- Accepts a K-beat stream of signed multiplier/multiplicand pairs (X, Y) and radix-8 recodes X into per-group one-hot magnitude flags (S/D/T/Q) plus a sign flag (N).
- Precomputes TMY = 3*Y and registers everything into the first PE.
- After the last beat it drives zero beats so the skewed array drains, then pulses DONE.

Parameters:
- WIDTH, 16: operand width (X, Y signed two's complement).
- GC, (WIDTH>>2)+2: recoding group count; derived, not overridden.
- ARRAY_DIM, 8: systolic array dimension; must be >= 2.
- KW, 8: width of the beat-count input.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a job; sampled only in IDLE.
- K_LEN  in  KW  number of beats in the job; sampled with START.
- X_IN  in  WIDTH  multiplier, signed.
- Y_IN  in  WIDTH  multiplicand, signed.
- IN_VALID  in  1  X_IN/Y_IN valid.
- IN_READY  out  1  feeder accepts a beat this cycle.
- S_OUT, D_OUT, T_OUT, Q_OUT, N_OUT  out  GC each  per-group flags for |digit| = 1/2/3/4, and digit < 0.
- Y_OUT  out  WIDTH  registered Y.
- TMY_OUT  out  WIDTH+2  registered 3*Y, sign-extended.
- OUT_VALID  out  1  output beat carries real data.
- OUT_LAST  out  1  final data beat of the job.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse when the job is finished and the pipeline is empty.

Behaviour:
- Reset: state=IDLE, both pipeline stages cleared. All outputs 0, including IN_READY, BUSY and DONE. RST mid-job aborts the job with no DONE.
- Recoding:
  - Sign-extend X to 3*GC+1 bits and append x[-1]=0.
  - Group i uses bits b3..b0 = x[3i+2], x[3i+1], x[3i], x[3i-1].
  - digit = -4*b3 + 2*b2 + b1 + b0, range -4..4.
  - Exactly one of S/D/T/Q is set when digit != 0; none when digit = 0.
  - N=1 only when digit < 0, so 4'b1111 gives all flags 0.
  - Invariant: X = sum(digit_i * 8^i).
- TMY = sign_ext(Y, WIDTH+2) + (sign_ext(Y, WIDTH+2) << 1). It is exact and never overflows.
- Pipeline: two register stages (stage 1 captures X/Y/valid/last; stage 2 holds the recoded flags and TMY). A beat accepted in cycle c appears on the outputs in cycle c+2. There is no downstream backpressure; the pipeline advances every cycle.
- Bubbles: any cycle without an accepted beat propagates a zero beat. A zero beat has all flags 0, Y_OUT=0, TMY_OUT=0, OUT_VALID=0 and OUT_LAST=0, which is harmless to OS accumulation.
- FSM:
  - IDLE: IN_READY=0. START with K_LEN != 0 goes to STREAM with cnt=K_LEN. START with K_LEN=0 pulses DONE next cycle and stays in IDLE.
  - STREAM: IN_READY=1. An accepted beat (IN_VALID & IN_READY) decrements cnt. The beat accepted with cnt=1 is tagged last and the FSM goes to FLUSH with fcnt=2*ARRAY_DIM-2. IN_VALID=0 inserts a bubble and leaves cnt unchanged.
  - FLUSH: IN_READY=0. fcnt decrements each cycle. On the cycle fcnt=1 the FSM goes to IDLE and DONE=1 for exactly one cycle.
- Timing: if the last beat is accepted in cycle c, OUT_LAST=1 in cycle c+2, and DONE=1 and BUSY=0 in cycle c+2*ARRAY_DIM-1.
- START outside IDLE is ignored. START and DONE may coincide, and the new job starts normally.

Decomposition:
- Package sa_r8_pkg holds:
  - the GC computation function;
  - the FSM state enum (IDLE/STREAM/FLUSH);
  - the digit-to-flag encoding constants.
- Sub-module booth_r8_enc is combinational: one 4-bit group in, s/d/t/q/n out, instantiated GC times.

Test Plan:
- X=3, Y=5, K_LEN=1 -> 2 cycles later T_OUT=6'b000001, others 0, Y_OUT=5, TMY_OUT=15, OUT_VALID=1, OUT_LAST=1; DONE at accept+15 (ARRAY_DIM=8).
- X=4 / X=-1 / X=-32768 -> Q[0]=N[0]=1 and S[1]=1 / S[0]=N[0]=1 only / S[5]=N[5]=1 only.
- Y=-32768 -> TMY_OUT=18'h28000; Y=32767 -> TMY_OUT=18'h17FFD.
- K_LEN=4 with IN_VALID=1,0,1,1,0,1 -> exactly 4 valid outputs, each 2 cycles after its acceptance; zero beats in the bubbles; OUT_LAST only on the 4th.
- START with K_LEN=0 -> DONE pulse next cycle, BUSY stays 0, IN_READY stays 0.
- RST asserted in STREAM after 2 of 5 beats -> next cycle all outputs 0 and IDLE; no DONE; a new START runs a clean job. Also check that START while BUSY is ignored.
